// File: rtl/run_detect_param.sv
// Run-length detector: flags when the last RUN_LEN accepted symbols are equal.
// Tracks the current run symbol and length, pulses z one clock after each
// qualifying sample and counts (saturating) the runs that reached RUN_LEN.
module run_detect_param #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [WIDTH-1:0]                   w,
  input  logic                               w_valid,
  input  logic [1:0]                         mode,
  output logic                               z,
  output logic [WIDTH-1:0]                   z_sym,
  output logic [$clog2(RUN_LEN+1)-1:0]       run_len,
  output logic [CNT_W-1:0]                   hit_cnt
);

  localparam int unsigned          LEN_W   = $clog2(RUN_LEN + 1);
  localparam logic [LEN_W-1:0]     RUN_MAX = LEN_W'(RUN_LEN);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state, state_n;
  logic                 z_n;
  logic [WIDTH-1:0]     z_sym_n;
  logic [LEN_W-1:0]     run_len_n;
  logic [CNT_W-1:0]     hit_cnt_n;
  logic [LEN_W-1:0]     cnt_n;
  logic                 new_run;
  logic                 permit;
  logic                 qual;
  logic                 reached;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      z       <= 1'b0;
      z_sym   <= '0;
      run_len <= '0;
      hit_cnt <= '0;
    end else begin
      state   <= state_n;
      z       <= z_n;
      z_sym   <= z_sym_n;
      run_len <= run_len_n;
      hit_cnt <= hit_cnt_n;
    end
  end

  // Next-state logic: clear beats an accepted sample, otherwise hold.
  always_comb begin
    state_n   = state;
    z_n       = 1'b0;
    z_sym_n   = z_sym;
    run_len_n = run_len;
    hit_cnt_n = hit_cnt;
    cnt_n     = run_len;
    new_run   = 1'b0;
    permit    = 1'b0;
    qual      = 1'b0;
    reached   = 1'b0;

    if (clr) begin
      state_n   = IDLE;
      run_len_n = '0;
      hit_cnt_n = '0;
    end else if (w_valid) begin
      new_run = (state == IDLE) || (w != z_sym);

      if (new_run) begin
        cnt_n = LEN_W'(1);
      end else if (run_len == RUN_MAX) begin
        cnt_n = RUN_MAX;
      end else begin
        cnt_n = run_len + LEN_W'(1);
      end

      case (mode)
        2'b00:   permit = 1'b1;
        2'b01:   permit = (w == '1);
        2'b10:   permit = (w == '0);
        default: permit = 1'b0;
      endcase

      qual = (cnt_n == RUN_MAX) && permit;
      // Count a hit only on the sample that first brings the run to RUN_LEN;
      // a saturated run continuing with equal symbols is not a new hit.
      reached = new_run || (run_len != RUN_MAX);

      state_n   = RUN;
      z_sym_n   = w;
      run_len_n = cnt_n;
      z_n       = qual;
      if (qual && reached && (hit_cnt != '1)) begin
        hit_cnt_n = hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_run_detect_param.sv
// Directed bench for run_detect_param: default instance (WIDTH=1, RUN_LEN=4,
// CNT_W=8) plus a WIDTH=4, RUN_LEN=1, CNT_W=2 instance for saturation.
module tb_run_detect_param;

  logic       clk = 1'b0;
  logic       rst;

  logic       clr, w, w_valid;
  logic [1:0] mode;
  logic       z;
  logic       z_sym;
  logic [2:0] run_len;
  logic [7:0] hit_cnt;

  logic       clr6, w_valid6;
  logic [3:0] w6;
  logic [1:0] mode6;
  logic       z6;
  logic [3:0] z_sym6;
  logic       run_len6;
  logic [1:0] hit_cnt6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_detect_param #(.WIDTH(1), .RUN_LEN(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .w       (w),
    .w_valid (w_valid),
    .mode    (mode),
    .z       (z),
    .z_sym   (z_sym),
    .run_len (run_len),
    .hit_cnt (hit_cnt)
  );

  run_detect_param #(.WIDTH(4), .RUN_LEN(1), .CNT_W(2)) dut6 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr6),
    .w       (w6),
    .w_valid (w_valid6),
    .mode    (mode6),
    .z       (z6),
    .z_sym   (z_sym6),
    .run_len (run_len6),
    .hit_cnt (hit_cnt6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle on the default instance, then sample 1 time unit after the edge.
  task automatic step(input logic wv, input logic v, input logic c);
    w       = wv;
    w_valid = v;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step6(input logic [3:0] wv);
    w6       = wv;
    w_valid6 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; w = 1'b0; w_valid = 1'b0; mode = 2'b00;
    clr6 = 1'b0; w6 = '0; w_valid6 = 1'b0; mode6 = 2'b00;

    #12;
    check("rst_z",       z,       0);
    check("rst_zsym",    z_sym,   0);
    check("rst_runlen",  run_len, 0);
    check("rst_hit",     hit_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: five zeros, z after the 4th and 5th
    step(0, 1, 0); check("t1_s1_z", z, 0); check("t1_s1_len", run_len, 1);
    step(0, 1, 0); check("t1_s2_z", z, 0);
    step(0, 1, 0); check("t1_s3_z", z, 0); check("t1_s3_len", run_len, 3);
    step(0, 1, 0); check("t1_s4_z", z, 1); check("t1_s4_hit", hit_cnt, 1);
    step(0, 1, 0); check("t1_s5_z", z, 1); check("t1_s5_len", run_len, 4);
    check("t1_hit", hit_cnt, 1);

    // 2: four ones then a zero
    step(1, 1, 0); check("t2_s1_z", z, 0); check("t2_s1_len", run_len, 1); check("t2_s1_sym", z_sym, 1);
    step(1, 1, 0); check("t2_s2_z", z, 0);
    step(1, 1, 0); check("t2_s3_z", z, 0);
    step(1, 1, 0); check("t2_s4_z", z, 1); check("t2_s4_hit", hit_cnt, 2);
    step(0, 1, 0); check("t2_s5_z", z, 0); check("t2_s5_len", run_len, 1);
    check("t2_s5_hit", hit_cnt, 2); check("t2_s5_sym", z_sym, 0);

    // 3: clear, then mode 01 ignores a zeros run
    step(0, 0, 1);
    check("t3_clr_len", run_len, 0); check("t3_clr_hit", hit_cnt, 0);
    check("t3_clr_z", z, 0); check("t3_clr_sym", z_sym, 0);
    mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0); check("t3_zero_z", z, 0);
    end
    check("t3_zero_len", run_len, 4); check("t3_zero_hit", hit_cnt, 0);
    step(1, 1, 0); check("t3_o1_z", z, 0);
    step(1, 1, 0); check("t3_o2_z", z, 0);
    step(1, 1, 0); check("t3_o3_z", z, 0);
    step(1, 1, 0); check("t3_o4_z", z, 1); check("t3_hit", hit_cnt, 1);

    // 4: gaps do not break a run
    mode = 2'b00;
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 1, 0); check("t4_len2", run_len, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0); check("t4_gap_z", z, 0); check("t4_gap_len", run_len, 2); check("t4_gap_sym", z_sym, 1);
    end
    step(1, 1, 0); check("t4_s3_z", z, 0); check("t4_s3_len", run_len, 3);
    step(1, 1, 0); check("t4_s4_z", z, 1); check("t4_hit", hit_cnt, 1);

    // 5: clear with valid drops the sample and restarts the run
    step(0, 0, 1);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    check("t5_pre_len", run_len, 3);
    step(1, 1, 1); check("t5_clr_len", run_len, 0); check("t5_clr_z", z, 0);
    step(1, 1, 0); check("t5_a_z", z, 0); check("t5_a_len", run_len, 1);
    step(1, 1, 0); check("t5_b_z", z, 0);
    step(1, 1, 0); check("t5_c_z", z, 0); check("t5_c_len", run_len, 3);
    check("t5_hit", hit_cnt, 0); check("t5_sym", z_sym, 1);
    rst = 1'b0;
    #2;
    check("t5_rst_z",   z,       0);
    check("t5_rst_sym", z_sym,   0);
    check("t5_rst_len", run_len, 0);
    check("t5_rst_hit", hit_cnt, 0);
    #3;
    rst = 1'b1;
    step(1, 1, 0); check("t5_post_len", run_len, 1); check("t5_post_z", z, 0);
    w_valid = 1'b0;

    // 6: RUN_LEN=1, CNT_W=2, hit counter saturates at 3
    step6(4'd3); check("t6_s1_z", z6, 1); check("t6_s1_hit", hit_cnt6, 1);
    step6(4'd5); check("t6_s2_z", z6, 1); check("t6_s2_hit", hit_cnt6, 2);
    step6(4'd3); check("t6_s3_z", z6, 1); check("t6_s3_hit", hit_cnt6, 3);
    step6(4'd5); check("t6_s4_z", z6, 1); check("t6_s4_hit", hit_cnt6, 3);
    step6(4'd3); check("t6_s5_z", z6, 1); check("t6_s5_hit", hit_cnt6, 3);
    check("t6_len", run_len6, 1); check("t6_sym", z_sym6, 3);
    step6(4'd3); check("t6_rep_z", z6, 1);
    mode6 = 2'b01;
    step6(4'hF); check("t6_m01_ones_z", z6, 1);
    step6(4'h3); check("t6_m01_other_z", z6, 0); check("t6_m01_sym", z_sym6, 3);
    w_valid6 = 1'b0;
    step6(4'h3); check("t6_m01_len", run_len6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
